// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log-stage barrel shifter (SLL/SRL/SRA/ROL), one level per stage,
// valid/ready handshake with whole-pipeline stall on output backpressure.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shift_amount,
    input  logic [1:0]         shift_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);
    logic [SHAMT_W-1:0] v_q, v_d;
    logic [WIDTH-1:0]   d_q [SHAMT_W];
    logic [WIDTH-1:0]   d_d [SHAMT_W];
    logic [SHAMT_W-1:0] a_q [SHAMT_W];
    logic [1:0]         o_q [SHAMT_W];
    logic [WIDTH-1:0]   d_in [SHAMT_W];
    logic [SHAMT_W-1:0] a_in [SHAMT_W];
    logic [1:0]         o_in [SHAMT_W];
    logic [WIDTH-1:0]   sra [SHAMT_W];
    logic               stall;

    assign out_valid = v_q[SHAMT_W-1];
    assign data_out  = d_q[SHAMT_W-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign busy      = |v_q;

    // Level k consumes stage k-1 (level 0 consumes the input port) and shifts by 2^k.
    always_comb begin
        v_d     = SHAMT_W'({v_q, in_valid && in_ready});
        d_in[0] = data_in;
        a_in[0] = shift_amount;
        o_in[0] = shift_op;
        for (int k = 1; k < SHAMT_W; k++) begin
            d_in[k] = d_q[k-1];
            a_in[k] = a_q[k-1];
            o_in[k] = o_q[k-1];
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            sra[k] = $signed(d_in[k]) >>> (1 << k);
            d_d[k] = !a_in[k][k]     ? d_in[k] :
                     o_in[k] == 2'b00 ? d_in[k] << (1 << k) :
                     o_in[k] == 2'b01 ? d_in[k] >> (1 << k) :
                     o_in[k] == 2'b10 ? sra[k] :
                     (d_in[k] << (1 << k)) | (d_in[k] >> (WIDTH - (1 << k)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            d_q <= '{default: '0};
        end else if (!stall) begin
            v_q <= v_d;
            d_q <= d_d;
            a_q <= a_in;
            o_q <= o_in;
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed checks at WIDTH=32 and WIDTH=8 plus a randomised
// WIDTH=8 run against a behavioural reference.
module tb_pipelined_shifter;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic        v32 = 0, or32 = 1, ir32, ov32, b32;
    logic [31:0] d32 = 0, q32;
    logic [4:0]  a32 = 0;
    logic [1:0]  op32 = 0;

    logic        v8 = 0, or8 = 1, ir8, ov8, b8;
    logic [7:0]  d8 = 0, q8;
    logic [2:0]  a8 = 0;
    logic [1:0]  op8 = 0;

    int total = 0;
    int bad = 0;

    pipelined_shifter #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .data_in(d32),
        .shift_amount(a32), .shift_op(op32), .out_valid(ov32), .out_ready(or32),
        .data_out(q32), .busy(b32)
    );

    pipelined_shifter #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .data_in(d8),
        .shift_amount(a8), .shift_op(op8), .out_valid(ov8), .out_ready(or8),
        .data_out(q8), .busy(b8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [1:0] op, input logic [7:0] d, input logic [2:0] a);
        logic [15:0] x;
        case (op)
            2'b00: x = {8'h00, d} << a;
            2'b01: x = {8'h00, d} >> a;
            2'b10: x = {{8{d[7]}}, d} >> a;
            default: x = ({d, d} << a) >> 8;
        endcase
        return x[7:0];
    endfunction

    task automatic op32_run(input string tag, input logic [1:0] op, input logic [31:0] d,
                            input logic [4:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        v32 = 1; d32 = d; a32 = a; op32 = op;
        @(posedge clk); #1;
        v32 = 0; d32 = 32'h0;
        chk({tag, "_busy"}, b32, 1);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_early"}, ov32, 0);
        @(posedge clk);
        #1 chk({tag, "_valid"}, ov32, 1);
        chk({tag, "_data"}, q32, exp);
        @(posedge clk);
        #1 chk({tag, "_once"}, ov32, 0);
    endtask

    task automatic op8_run(input string tag, input logic [1:0] op, input logic [7:0] d,
                           input logic [2:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        v8 = 1; d8 = d; a8 = a; op8 = op;
        @(posedge clk); #1;
        v8 = 0;
        @(posedge clk);
        #1 chk({tag, "_early"}, ov8, 0);
        @(posedge clk);
        #1 chk({tag, "_valid"}, ov8, 1);
        chk({tag, "_data"}, q8, {24'h0, exp});
        @(posedge clk);
        #1 chk({tag, "_once"}, ov8, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_ov", ov32, 0);
        chk("rst_busy", b32, 0);
        chk("rst_data", q32, 0);
        chk("rst_ir", ir32, 1);
        chk("rst_data8", q8, 0);

        op32_run("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        op32_run("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
        op32_run("sra4n", 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        op32_run("sra4p", 2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000);
        op32_run("rol1",  2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003);
        op32_run("sra0",  2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        op32_run("rol0",  2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

        // back-to-back stream, 8 SLL ops of 1 by 0..7
        @(posedge clk); #1;
        v32 = 1; d32 = 32'h1; a32 = 5'd0; op32 = 2'b00;
        for (int t = 0; t < 13; t++) begin
            @(posedge clk); #1;
            if (t < 7) a32 = 5'(t + 1);
            else v32 = 0;
            if (t >= 4 && t < 12) begin
                chk("stream_v", ov32, 1);
                chk("stream_d", q32, 32'h1 << (t - 4));
            end else begin
                chk("stream_idle", ov32, 0);
            end
        end

        // same stream with 3 cycles of output backpressure at the first result
        begin
            int sent = 0, got = 0, hold = 0, stalls = 0, cyc = 0;
            bit seen = 0;
            bit acc, pop;
            while (got < 8 && cyc < 60) begin
                @(posedge clk);
                if (hold > 0) hold--;
                #1;
                cyc++;
                if (!seen && ov32) begin
                    seen = 1;
                    hold = 3;
                end
                or32 = (hold == 0);
                v32 = (sent < 8);
                d32 = 32'h1;
                a32 = 5'(sent);
                #1;
                chk("bp_ready", ir32, (hold == 0));
                if (!ir32) begin
                    stalls++;
                    chk("bp_hold_data", q32, 32'h1);
                end
                acc = v32 && ir32;
                pop = ov32 && or32;
                if (pop) begin
                    chk("bp_data", q32, 32'h1 << got);
                    got++;
                end
                if (acc) sent++;
            end
            @(posedge clk); #1;
            v32 = 0; or32 = 1;
            chk("bp_count", got, 8);
            chk("bp_stalls", stalls, 3);
            chk("bp_no_dup", ov32, 0);
        end

        // reset in flight discards all entries
        @(posedge clk); #1;
        v32 = 1; d32 = 32'h5; a32 = 5'd1; op32 = 2'b00;
        repeat (3) @(posedge clk);
        #1 v32 = 0;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_ov", ov32, 0);
        chk("mid_rst_busy", b32, 0);
        chk("mid_rst_data", q32, 0);
        begin
            int seen_v = 0;
            for (int t = 0; t < 8; t++) begin
                @(posedge clk);
                #1 if (ov32) seen_v++;
            end
            chk("mid_rst_never", seen_v, 0);
        end

        op8_run("w8_sra3", 2'b10, 8'h90, 3'd3, 8'hF2);
        op8_run("w8_rol7", 2'b11, 8'h81, 3'd7, 8'hC0);

        // randomised WIDTH=8 run against the reference
        begin
            int sent = 0, popped = 0, cyc = 0;
            bit pend = 0;
            logic [7:0] q[$];
            logic [7:0] e;
            while (popped < 2000 && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
                if (!pend && sent < 2000 && $urandom_range(0, 3) != 0) begin
                    pend = 1;
                    d8 = 8'($urandom);
                    a8 = 3'($urandom);
                    op8 = 2'($urandom);
                end
                v8 = pend;
                or8 = ($urandom_range(0, 3) != 0);
                #1;
                if (ov8 && or8) begin
                    if (q.size() == 0) chk("rnd_extra", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("rnd", {24'h0, q8}, {24'h0, e});
                    end
                    popped++;
                end
                if (v8 && ir8) begin
                    q.push_back(ref8(op8, d8, a8));
                    pend = 0;
                    sent++;
                end
            end
            @(posedge clk); #1;
            v8 = 0; or8 = 1;
            chk("rnd_count", popped, 2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
